// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: shared state encoding, default memory map and width helper for the bus fabric
package soc_bus_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;
  localparam logic [3:0] MAP_SRAM = 4'h4;
  localparam logic [3:0] MAP_ROM  = 4'h0;
  localparam logic [3:0] MAP_UART = 4'he;
  localparam logic [3:0] MAP_GPIO = 4'hd;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/soc_bus_rdmux.sv
// soc_bus_rdmux: parametrised one-hot AND-OR read-data mux
module soc_bus_rdmux #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout
);
  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) dout = dout | (din[i*W +: W] & {W{sel[i]}});
  end
endmodule

// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: address-decoding data-bus interconnect with wait stall, timeout/unmapped abort and fault capture
module soc_bus_fabric
  import soc_bus_pkg::*;
#(
  parameter int NSLV = 4,
  parameter int SEL_MSB = 31,
  parameter int SEL_LSB = 28,
  parameter logic [NSLV*(SEL_MSB-SEL_LSB+1)-1:0] SLV_BASE = {MAP_GPIO, MAP_UART, MAP_ROM, MAP_SRAM},
  parameter int TIMEOUT = 255,
  parameter bit ABORT_UNMAPPED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_cen,
  input  logic              ram_wen,
  input  logic [31:0]       ram_addr,
  output logic [31:0]       ram_rdata,
  output logic              ram_abort,
  output logic              cpu_en,
  output logic [NSLV-1:0]   s_ce,
  input  logic [NSLV*32-1:0] s_rdata,
  input  logic [NSLV-1:0]   s_wait,
  input  logic              err_clr,
  output logic              err_valid,
  output logic [31:0]       err_addr,
  output logic              err_wr,
  output logic              err_tout
);
  localparam int SW = SEL_MSB - SEL_LSB + 1;
  localparam int CW = clog2(TIMEOUT + 1);
  state_t state, state_nxt;
  logic [CW-1:0] wait_cnt, cnt_nxt;
  logic [NSLV-1:0] hit, sel_d;
  logic sw, unmapped, at_max, en_fsm, forced, unm_ev, fault;
  always_comb begin
    hit = '0;
    for (int i = NSLV - 1; i >= 0; i--)
      if (ram_cen && ram_addr[SEL_MSB:SEL_LSB] == SLV_BASE[i*SW +: SW]) begin
        hit = '0;
        hit[i] = 1'b1;
      end
  end
  assign forced   = state == ST_FORCE;
  assign s_ce     = forced ? '0 : hit;
  assign sw       = |(hit & s_wait);
  assign unmapped = ram_cen & ~|hit;
  assign at_max   = wait_cnt == CW'(TIMEOUT);
  always_comb begin
    state_nxt = ST_IDLE;
    cnt_nxt = '0;
    en_fsm = 1'b1;
    case (state)
      ST_IDLE: if (sw) begin
        state_nxt = ST_WAIT;
        cnt_nxt = CW'(1);
        en_fsm = 1'b0;
      end
      ST_WAIT: if (sw) begin
        state_nxt = at_max ? ST_FORCE : ST_WAIT;
        cnt_nxt = at_max ? wait_cnt : wait_cnt + 1'b1;
        en_fsm = 1'b0;
      end
      default: ;
    endcase
  end
  assign cpu_en = rst | en_fsm;
  assign unm_ev = en_fsm & ~forced & unmapped;
  assign fault  = forced | unm_ev;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      wait_cnt <= '0;
      sel_d <= '0;
      ram_abort <= 1'b0;
      err_valid <= 1'b0;
      err_addr <= '0;
      err_wr <= 1'b0;
      err_tout <= 1'b0;
    end else begin
      state <= state_nxt;
      wait_cnt <= cnt_nxt;
      if (en_fsm) sel_d <= forced ? '0 : hit;
      ram_abort <= forced | (unm_ev & ABORT_UNMAPPED);
      if (fault && (!err_valid || err_clr)) begin
        err_valid <= 1'b1;
        err_addr <= ram_addr;
        err_wr <= ram_wen;
        err_tout <= forced;
      end else if (err_clr) err_valid <= 1'b0;
    end
  end
  soc_bus_rdmux #(.N(NSLV), .W(32)) u_rdmux (
    .sel  (rst ? '0 : sel_d),
    .din  (s_rdata),
    .dout (ram_rdata)
  );
endmodule
